reel_speed_scheduler: RTL and testbench

- Sequences the speed word fed to the reel clock divider for one slot-machine reel.
- On a spin request it ramps the divider speed up in fixed steps, holds it at cruise speed until a stop request or a cruise timeout, then ramps it back down to idle speed.
- Issues a one-cycle divider resync pulse on every speed change and signals completion.
- Sits between the game FSM (start/stop) and the clock divider (speed/rst inputs).

---
 rtl/reel_speed_scheduler.sv | 110 +++++++++++
 tb/tb_reel_speed_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reel_speed_scheduler.sv
// Reel speed sequencer: ramps the clock-divider speed word up to cruise, holds it,
// then ramps it back down to idle, pulsing div_rst on every speed change.
module reel_speed_scheduler #(
    parameter int unsigned MIN_SPEED     = 2,
    parameter int unsigned MAX_SPIN      = 20,
    parameter int unsigned SPEED_STEP    = 2,
    parameter int unsigned STEP_CYCLES   = 2500000,
    parameter int unsigned CRUISE_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic [25:0] speed,
    output logic        div_rst,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {S_IDLE, S_ACCEL, S_CRUISE, S_DECEL, S_DONE} state_t;

    localparam logic [31:0] STEP_LAST   = 32'(STEP_CYCLES - 1);
    localparam logic [31:0] CRUISE_LAST = 32'(CRUISE_CYCLES - 1);
    localparam logic [26:0] MIN_W       = 27'(MIN_SPEED);
    localparam logic [26:0] MAX_W       = 27'(MAX_SPIN);
    localparam logic [26:0] STEP_W      = 27'(SPEED_STEP);
    localparam logic [25:0] MIN_26      = 26'(MIN_SPEED);
    localparam logic [25:0] MAX_26      = 26'(MAX_SPIN);
    localparam logic [25:0] STEP_26     = 26'(SPEED_STEP);

    state_t      r_state, w_state_nxt;
    logic [25:0] r_step_tmr, r_cruise_tmr, r_speed;
    logic        r_div_rst, r_busy, r_done;
    logic        w_step, w_cruise_to;
    logic [26:0] w_sum;
    logic [25:0] w_up, w_dn, w_speed_nxt;
    logic        w_div_rst_nxt, w_busy_nxt, w_done_nxt;

    assign w_step      = ({6'd0, r_step_tmr} == STEP_LAST);
    assign w_cruise_to = ({6'd0, r_cruise_tmr} == CRUISE_LAST);

    // Saturating ramp arithmetic done in 27 bits so neither end can wrap
    assign w_sum = {1'b0, r_speed} + STEP_W;
    assign w_up  = (w_sum > MAX_W) ? MAX_26 : w_sum[25:0];
    assign w_dn  = ({1'b0, r_speed} < (MIN_W + STEP_W)) ? MIN_26 : (r_speed - STEP_26);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_step_tmr   <= '0;
            r_cruise_tmr <= '0;
            r_speed      <= MIN_26;
            r_div_rst    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_speed   <= w_speed_nxt;
            r_div_rst <= w_div_rst_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            if (w_state_nxt != r_state) begin
                r_step_tmr   <= '0;
                r_cruise_tmr <= '0;
            end else begin
                if (r_state == S_ACCEL || r_state == S_DECEL)
                    r_step_tmr <= w_step ? '0 : r_step_tmr + 26'd1;
                if (r_state == S_CRUISE)
                    r_cruise_tmr <= r_cruise_tmr + 26'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_ACCEL;
            S_ACCEL: begin
                if (stop)                        w_state_nxt = S_DECEL;
                else if (w_step && w_up == MAX_26) w_state_nxt = S_CRUISE;
            end
            S_CRUISE: if (stop || w_cruise_to) w_state_nxt = S_DECEL;
            S_DECEL:  if (w_step && w_dn == MIN_26) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_speed_nxt = r_speed;
        case (r_state)
            S_IDLE:   w_speed_nxt = MIN_26;
            S_ACCEL:  if (!stop && w_step) w_speed_nxt = w_up;
            S_CRUISE: w_speed_nxt = MAX_26;
            S_DECEL:  if (w_step) w_speed_nxt = w_dn;
            default:  w_speed_nxt = r_speed;
        endcase
        // Suppressing back-to-back pulses only matters when a step lands every cycle
        w_div_rst_nxt = !r_div_rst &&
                        ((r_state == S_IDLE && start) || (w_speed_nxt != r_speed));
        w_busy_nxt    = (w_state_nxt == S_ACCEL) || (w_state_nxt == S_CRUISE) ||
                        (w_state_nxt == S_DECEL);
        w_done_nxt    = (w_state_nxt == S_DONE);
    end

    assign speed   = r_speed;
    assign div_rst = r_div_rst;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_reel_speed_scheduler.sv
// Self-checking bench for reel_speed_scheduler: per-edge output trajectories are compared
// against a phase-level model of the ramp/cruise/ramp profile.
module tb_reel_speed_scheduler;
    localparam int P_MIN  = 2;
    localparam int P_MAX  = 8;
    localparam int P_STEP = 4;
    localparam int P_SC   = 4;
    localparam int P_CC   = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [25:0] speed;
    logic        div_rst, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    // Packed {speed, div_rst, busy, done} as seen #1 after each clock edge
    logic [28:0] obs  [64];
    logic [28:0] expv [64];

    reel_speed_scheduler #(
        .MIN_SPEED    (P_MIN),
        .MAX_SPIN     (P_MAX),
        .SPEED_STEP   (P_STEP),
        .STEP_CYCLES  (P_SC),
        .CRUISE_CYCLES(P_CC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .speed  (speed),
        .div_rst(div_rst),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic void set_exp(input int idx, input int spd, input bit d, input bit b, input bit dn);
        expv[idx] = {26'(spd), d, b, dn};
    endfunction

    // Edge 0 is the edge that samples start. Stop is honoured only if sampled in ACCEL/CRUISE.
    function automatic void build_model(input int stop_edge, output int n, output int dec_e, output int done_e);
        int e, spd, nxt, nspd;
        e = 0;
        spd = P_MIN;
        dec_e = -1;
        set_exp(0, spd, 1'b1, 1'b1, 1'b0);
        while (dec_e < 0 && spd < P_MAX) begin
            nxt = e + P_SC;
            if (stop_edge > e && stop_edge <= nxt) begin
                for (int i = e + 1; i <= stop_edge; i++) set_exp(i, spd, 1'b0, 1'b1, 1'b0);
                dec_e = stop_edge;
                e = stop_edge;
            end else begin
                for (int i = e + 1; i < nxt; i++) set_exp(i, spd, 1'b0, 1'b1, 1'b0);
                spd = (spd + P_STEP > P_MAX) ? P_MAX : spd + P_STEP;
                set_exp(nxt, spd, 1'b1, 1'b1, 1'b0);
                e = nxt;
            end
        end
        if (dec_e < 0) begin
            nxt = e + P_CC;
            if (stop_edge > e && stop_edge < nxt) nxt = stop_edge;
            for (int i = e + 1; i <= nxt; i++) set_exp(i, spd, 1'b0, 1'b1, 1'b0);
            dec_e = nxt;
            e = nxt;
        end
        do begin
            nxt = e + P_SC;
            for (int i = e + 1; i < nxt; i++) set_exp(i, spd, 1'b0, 1'b1, 1'b0);
            nspd = (spd - P_STEP < P_MIN) ? P_MIN : spd - P_STEP;
            set_exp(nxt, nspd, nspd != spd, nspd != P_MIN, nspd == P_MIN);
            spd = nspd;
            e = nxt;
        end while (spd > P_MIN);
        done_e = e;
        set_exp(e + 1, P_MIN, 1'b0, 1'b0, 1'b0);
        n = e + 2;
    endfunction

    // Drives one spin from IDLE and records outputs; noise adds start pulses while busy/done
    // and stop pulses from DECEL entry onwards, all of which must be ignored.
    task automatic run_spin(input int stop_edge, input bit noise, input int max_e, output int n);
        int dec_e, done_e;
        build_model(stop_edge, n, dec_e, done_e);
        if (max_e < n) n = max_e;
        start = 1'b1;
        stop  = (stop_edge == 0);
        for (int e = 0; e < n; e++) begin
            @(posedge clk); #1;
            obs[e] = {speed, div_rst, busy, done};
            start = noise && (e + 1 <= done_e + 1) && ($urandom_range(0, 1) == 1);
            stop  = (e + 1 == stop_edge) ||
                    (noise && e + 1 > dec_e && e + 1 <= done_e + 1 && ($urandom_range(0, 1) == 1));
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        @(posedge clk); #1;
        n_tests++;
        if ({speed, div_rst, busy, done} !== {26'd2, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: got %0d,%b want 2,000", speed, {div_rst, busy, done});
        end
        run_spin(-1, 1'b0, 6, n);
        n_tests++;
        if (obs[5] !== {26'd6, 3'b010}) begin
            n_fail++;
            $display("FAIL pre_reset_accel: got %0d,%b want 6,010", obs[5][28:3], obs[5][2:0]);
        end
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if ({speed, div_rst, busy, done} !== {26'd2, 3'b000}) begin
            n_fail++;
            $display("FAIL async_reset: got %0d,%b want 2,000", speed, {div_rst, busy, done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stop = ~stop;
            @(posedge clk); #1;
            n_tests++;
            if ({speed, div_rst, busy, done} !== {26'd2, 3'b000}) begin
                n_fail++;
                $display("FAIL idle_stop_toggle %0d: got %0d,%b want 2,000", i, speed, {div_rst, busy, done});
            end
        end
        stop = 1'b0;
    endtask

    task automatic test_full_spin;
        int n;
        run_spin(-1, 1'b0, 64, n);
        for (int e = 0; e < n; e++) begin
            n_tests++;
            if (obs[e] !== expv[e]) begin
                n_fail++;
                $display("FAIL full_spin e=%0d: got %0d,%b want %0d,%b", e, obs[e][28:3], obs[e][2:0], expv[e][28:3], expv[e][2:0]);
            end
        end
        n_tests++;
        if (obs[4] !== {26'd6, 3'b110} || obs[8] !== {26'd8, 3'b110} || obs[22] !== {26'd4, 3'b110} ||
            obs[26] !== {26'd2, 3'b101} || obs[27] !== {26'd2, 3'b000}) begin
            n_fail++;
            $display("FAIL full_spin_milestones: got e4=%0d e8=%0d e22=%0d e26=%0d,%b e27=%b want 6 8 4 2,101 000",
                     obs[4][28:3], obs[8][28:3], obs[22][28:3], obs[26][28:3], obs[26][2:0], obs[27][2:0]);
        end
    endtask

    task automatic test_early_stop;
        int n;
        int max_spd;
        run_spin(P_SC + 2, 1'b0, 64, n);
        max_spd = 0;
        for (int e = 0; e < n; e++) begin
            if (int'(obs[e][28:3]) > max_spd) max_spd = int'(obs[e][28:3]);
            n_tests++;
            if (obs[e] !== expv[e]) begin
                n_fail++;
                $display("FAIL early_stop e=%0d: got %0d,%b want %0d,%b", e, obs[e][28:3], obs[e][2:0], expv[e][28:3], expv[e][2:0]);
            end
        end
        n_tests++;
        if (max_spd !== 6 || n !== 12) begin
            n_fail++;
            $display("FAIL early_stop_peak: got peak=%0d len=%0d want peak=6 len=12", max_spd, n);
        end
    endtask

    task automatic test_ignored_requests;
        int n;
        for (int k = 0; k < 3; k++) begin
            run_spin(-1, 1'b1, 64, n);
            for (int e = 0; e < n; e++) begin
                n_tests++;
                if (obs[e] !== expv[e]) begin
                    n_fail++;
                    $display("FAIL ignored_req k=%0d e=%0d: got %0d,%b want %0d,%b", k, e, obs[e][28:3], obs[e][2:0], expv[e][28:3], expv[e][2:0]);
                end
            end
        end
    endtask

    task automatic test_simultaneous;
        int n;
        int n_done;
        run_spin(2 * P_SC + P_CC, 1'b0, 64, n);
        n_done = 0;
        for (int e = 0; e < n; e++) begin
            n_done += int'(obs[e][0]);
            n_tests++;
            if (obs[e] !== expv[e]) begin
                n_fail++;
                $display("FAIL stop_timeout e=%0d: got %0d,%b want %0d,%b", e, obs[e][28:3], obs[e][2:0], expv[e][28:3], expv[e][2:0]);
            end
        end
        n_tests++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL stop_timeout_done_count: got %0d want 1", n_done);
        end
    endtask

    task automatic test_reset_mid_decel;
        int n;
        run_spin(-1, 1'b0, 23, n);
        n_tests++;
        if (obs[22] !== {26'd4, 3'b110}) begin
            n_fail++;
            $display("FAIL mid_decel_pre: got %0d,%b want 4,110", obs[22][28:3], obs[22][2:0]);
        end
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if ({speed, div_rst, busy, done} !== {26'd2, 3'b000}) begin
            n_fail++;
            $display("FAIL mid_decel_reset: got %0d,%b want 2,000", speed, {div_rst, busy, done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if ({speed, div_rst, busy, done} !== {26'd2, 3'b000}) begin
                n_fail++;
                $display("FAIL mid_decel_after %0d: got %0d,%b want 2,000", i, speed, {div_rst, busy, done});
            end
        end
        run_spin(-1, 1'b0, 64, n);
        for (int e = 0; e < n; e++) begin
            n_tests++;
            if (obs[e] !== expv[e]) begin
                n_fail++;
                $display("FAIL respin e=%0d: got %0d,%b want %0d,%b", e, obs[e][28:3], obs[e][2:0], expv[e][28:3], expv[e][2:0]);
            end
        end
    endtask

    task automatic test_random;
        int n;
        int se;
        for (int k = 0; k < 10; k++) begin
            se = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 2 * P_SC + P_CC + 2));
            run_spin(se, 1'b1, 64, n);
            for (int e = 0; e < n; e++) begin
                n_tests++;
                if (obs[e] !== expv[e]) begin
                    n_fail++;
                    $display("FAIL random k=%0d stop_edge=%0d e=%0d: got %0d,%b want %0d,%b", k, se, e, obs[e][28:3], obs[e][2:0], expv[e][28:3], expv[e][2:0]);
                end
            end
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #12 rst = 1'b0;
        test_reset();
        test_full_spin();
        test_early_stop();
        test_ignored_requests();
        test_simultaneous();
        test_reset_mid_decel();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
